// File: rtl/imem_loader_if.sv
// Host-to-loader byte stream plus the loader's instruction-memory write port and
// core-control outputs.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata, cpu_reset, busy, done, err
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata, cpu_reset, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: length-prefixed byte stream -> big-endian 32-bit words written to
// instruction memory from address 0, holding the core in reset until the load completes.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam logic [31:0] CAP = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        DONE
    } state_t;

    state_t            state;
    logic [7:0]        len_hi;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   k;
    logic [1:0]        b;
    logic [23:0]       asm_hi;
    logic              xfer;
    logic [15:0]       len_word;
    logic [ADDR_W:0]   k_next;

    assign xfer     = bus.byte_valid & bus.byte_ready;
    assign len_word = {len_hi, bus.byte_data};
    assign k_next   = k + 1'b1;

    // Only the first three bytes are held; the fourth goes straight into im_wdata, so
    // the assembly path is free again in the same cycle the write is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            len_hi         <= '0;
            n_words        <= '0;
            k              <= '0;
            b              <= '0;
            asm_hi         <= '0;
            bus.byte_ready <= 1'b0;
            bus.im_we      <= 1'b0;
            bus.im_addr    <= '0;
            bus.im_wdata   <= '0;
            bus.cpu_reset  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.im_we <= 1'b0;
            bus.done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= LEN_HI;
                        bus.err        <= 1'b0;
                        bus.cpu_reset  <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.byte_ready <= 1'b1;
                        k              <= '0;
                        b              <= '0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi <= bus.byte_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        if (len_word == 16'd0) begin
                            state          <= DONE;
                            bus.byte_ready <= 1'b0;
                            bus.done       <= 1'b1;
                        end else if (32'(len_word) > CAP) begin
                            // Oversized program: abort with the core still held in reset.
                            state          <= IDLE;
                            bus.err        <= 1'b1;
                            bus.busy       <= 1'b0;
                            bus.byte_ready <= 1'b0;
                        end else begin
                            state   <= DATA;
                            n_words <= (ADDR_W + 1)'(len_word);
                            k       <= '0;
                            b       <= '0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (b == 2'd3) begin
                            bus.im_wdata <= {asm_hi, bus.byte_data};
                            bus.im_addr  <= k[ADDR_W-1:0];
                            bus.im_we    <= 1'b1;
                            k            <= k_next;
                            b            <= '0;
                            if (k_next == n_words) begin
                                state          <= DONE;
                                bus.byte_ready <= 1'b0;
                                bus.done       <= 1'b1;
                            end
                        end else begin
                            case (b)
                                2'd0:    asm_hi[23:16] <= bus.byte_data;
                                2'd1:    asm_hi[15:8]  <= bus.byte_data;
                                default: asm_hi[7:0]   <= bus.byte_data;
                            endcase
                            b <= b + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.cpu_reset <= 1'b0;
                    bus.busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams are checked against a word-list model
// derived directly from the length-prefix / big-endian packing rules.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int CAP    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
    imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [7:0]         stream[$];
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] got_q[$];
    int                 exp_n;
    logic               exp_err;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (bus.im_we === 1'b1) got_q.push_back({bus.im_addr, bus.im_wdata});

    function automatic void build_expect(input logic [7:0] s[$]);
        exp_q.delete();
        exp_n   = {s[0], s[1]};
        exp_err = (exp_n > CAP);
        if (!exp_err)
            for (int w = 0; w < exp_n; w++)
                exp_q.push_back({ADDR_W'(w), s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] d, input int max_idle);
        int idle;
        int waitc;
        idle = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
        repeat (idle) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        waitc = 0;
        while (bus.byte_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) check_val("ready_timeout", 0, 1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic run_session(input int max_idle, input string nm);
        build_expect(stream);
        got_q.delete();
        pulse_start();
        check_val({nm, ".ready_after_start"}, bus.byte_ready, 1);
        check_val({nm, ".busy_after_start"}, bus.busy, 1);
        check_val({nm, ".err_cleared"}, bus.err, 0);
        check_val({nm, ".cpu_reset_held"}, bus.cpu_reset, 1);
        foreach (stream[i]) put_byte(stream[i], max_idle);
        if (exp_err) begin
            check_val({nm, ".err_set"}, bus.err, 1);
            check_val({nm, ".err_idle"}, bus.busy, 0);
            check_val({nm, ".err_no_done"}, bus.done, 0);
        end else begin
            check_val({nm, ".done_pulse"}, bus.done, 1);
            check_val({nm, ".last_we_with_done"}, bus.im_we, (exp_n != 0) ? 1 : 0);
            check_val({nm, ".cpu_reset_still_held"}, bus.cpu_reset, 1);
        end
        @(negedge clk);
        check_val({nm, ".done_one_cycle"}, bus.done, 0);
        check_val({nm, ".busy_end"}, bus.busy, 0);
        check_val({nm, ".ready_end"}, bus.byte_ready, 0);
        check_val({nm, ".cpu_reset_end"}, bus.cpu_reset, exp_err ? 1 : 0);
        repeat (2) @(negedge clk);
        check_val({nm, ".write_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val({nm, ".write"}, got_q[i], exp_q[i]);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst.byte_ready", bus.byte_ready, 0);
        check_val("rst.im_we", bus.im_we, 0);
        check_val("rst.im_addr", bus.im_addr, 0);
        check_val("rst.im_wdata", bus.im_wdata, 0);
        check_val("rst.cpu_reset", bus.cpu_reset, 1);
        check_val("rst.busy", bus.busy, 0);
        check_val("rst.done", bus.done, 0);
        check_val("rst.err", bus.err, 0);
        rst = 1'b0;
        repeat (10) begin
            bus.byte_valid = 1'($urandom);
            bus.byte_data  = 8'($urandom);
            @(negedge clk);
            check_val("idle.byte_ready", bus.byte_ready, 0);
            check_val("idle.cpu_reset", bus.cpu_reset, 1);
        end
        bus.byte_valid = 1'b0;

        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_session(0, "b2b");
        run_session(3, "gappy");

        stream = '{8'h00, 8'h00};
        run_session(0, "empty");

        stream = '{8'h04, 8'h01};
        run_session(1, "too_long");

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 7));
            stream = '{8'(n >> 8), 8'(n)};
            repeat (4 * n) stream.push_back(8'($urandom));
            run_session((r % 2 == 1) ? 2 : 0, "rand");
        end

        stream = '{8'h04, 8'h00};
        repeat (4 * CAP) stream.push_back(8'($urandom));
        run_session(0, "full");

        got_q.delete();
        pulse_start();
        put_byte(8'h00, 0);
        put_byte(8'h02, 0);
        put_byte(8'h11, 0);
        put_byte(8'h22, 0);
        pulse_start();
        put_byte(8'h33, 0);
        put_byte(8'h44, 0);
        put_byte(8'h55, 0);
        rst = 1'b1;
        #1;
        check_val("mid_rst.byte_ready", bus.byte_ready, 0);
        check_val("mid_rst.im_we", bus.im_we, 0);
        check_val("mid_rst.im_addr", bus.im_addr, 0);
        check_val("mid_rst.im_wdata", bus.im_wdata, 0);
        check_val("mid_rst.cpu_reset", bus.cpu_reset, 1);
        check_val("mid_rst.busy", bus.busy, 0);
        check_val("mid_rst.done", bus.done, 0);
        check_val("mid_rst.err", bus.err, 0);
        repeat (3) begin
            @(negedge clk);
            bus.byte_valid = 1'($urandom);
            bus.byte_data  = 8'($urandom);
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            bus.byte_valid = 1'($urandom);
        end
        bus.byte_valid = 1'b0;
        check_val("mid_rst.after_busy", bus.busy, 0);
        check_val("mid_rst.write_count", got_q.size(), 1);
        if (got_q.size() > 0) check_val("mid_rst.word0", got_q[0], {ADDR_W'(0), 32'h11223344});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
